up_control_unit: RTL
====================

Name: up_control_unit

Overview:
- Control-unit FSM paired with the 8-bit accumulator datapath (5-bit PC, 32x8 RAM, A register, adder/subtractor).
- Consumes datapath status: opcode IR[7:5], Aeq0, Apos.
- Drives every datapath control strobe through a fetch / decode / execute sequence.
- Top level instantiates it beside the datapath; outputs connect one-to-one to the datapath control inputs.

Parameters:
MEM_WAIT, 0, extra DECODE-to-EXECUTE wait cycles for a slow RAM read (0..7)
WAITW, 3, width of the wait counter

Ports:
CLOCK  input  1  single system clock, rising edge
RESET  input  1  synchronous, active-high reset
IR  input  3  opcode IR[7:5] from the datapath IR register
Aeq0  input  1  A == 0
Apos  input  1  A[7] == 0
Enter  input  1  input-valid strobe (used only with UP_CU_INPUT_HANDSHAKE_EN)
IRload  output  1  load IR
JMPmux  output  1  1 = PC <- IR[4:0]; 0 = PC+1
PCload  output  1  load PC
Meminst  output  1  1 = RAM address from IR[4:0]; 0 = PC
MemWr  output  1  RAM write
Aload  output  1  load A
Sub  output  1  1 = subtract
Asel  output  2  00 = add/sub result, 01 = Input, 1x = RAM data
Halt  output  1  machine halted
State  output  3  current state, for debug

Behaviour:
- Interface: one clock, CLOCK. RESET is synchronous and active-high. RESET=1 at a rising edge forces state START; it takes priority over every transition, including mid-instruction and from HALT.
- State encoding (registered, 3 bits): START=000, FETCH=001, DECODE=010, WAIT=011, EXECUTE=100, INWAIT=101, HALT=111.
- Outputs are Moore-style, decoded from the state plus the IR input. All outputs default to 0. State mirrors the state register.
- START: all strobes 0 -> FETCH.
- FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0 -> DECODE.
- DECODE: Meminst=1, no loads.
  - IR=111 -> HALT.
  - Else if MEM_WAIT>0 -> WAIT, with counter loaded to MEM_WAIT-1.
  - Else -> EXECUTE.
- WAIT: Meminst=1. Counter decrements each cycle; at 0 -> EXECUTE.
- EXECUTE, by opcode (all -> FETCH):
  - 000 LOAD: Meminst=1, Asel=10, Aload=1.
  - 001 STORE: Meminst=1, MemWr=1.
  - 010 ADD: Meminst=1, Asel=00, Sub=0, Aload=1.
  - 011 SUB: Meminst=1, Asel=00, Sub=1, Aload=1.
  - 100 IN: Asel=01, Aload=1.
  - 101 JZ: if Aeq0 then JMPmux=1, PCload=1.
  - 110 JPOS: if Apos then JMPmux=1, PCload=1.
  - 111: unreachable; strobes 0.
- HALT: Halt=1, all strobes 0. Stays in HALT until RESET.
- Instruction latency: 3 cycles + MEM_WAIT. Strobes are single-cycle pulses.
- MemWr and Aload are never asserted together. PC wraps 31->0 (datapath property, no control action).
- A not-taken jump still costs EXECUTE; PC already holds PC+1 from FETCH.

Optional Feature:
- Macro: UP_CU_INPUT_HANDSHAKE_EN.
- Defined: EXECUTE with IR=100 and Enter=0 -> INWAIT with all strobes 0. INWAIT holds until Enter=1, then asserts Asel=01, Aload=1 that same cycle -> FETCH. Enter=1 already in EXECUTE loads immediately. RESET in INWAIT -> START.
- Undefined: Enter ignored; INWAIT unreachable; IN completes in EXECUTE.

Decomposition:
- Package up_cu_pkg: opcode localparams (OP_LOAD..OP_HALT), state encodings, Asel codes (ASEL_RESULT=00, ASEL_INPUT=01, ASEL_RAM=10).
- One sub-module: up_cu_outdec, a combinational state+opcode+flags -> strobe decoder. The top module holds the state register, next-state logic and wait counter.

Test Plan:
- Reset then LOAD 5 (IR=000): states START,FETCH,DECODE,EXECUTE. FETCH shows IRload=PCload=1; EXECUTE shows Meminst=1, Asel=10, Aload=1; back to FETCH on cycle 4.
- JZ with Aeq0=1, then with Aeq0=0: first gives EXECUTE JMPmux=1, PCload=1; second gives no strobes. JPOS with Apos=0: no jump.
- SUB vs ADD: Sub=1 only for opcode 011; Asel=00 and Aload=1 for both; MemWr=0 throughout.
- HALT (IR=111): DECODE -> HALT, Halt=1 held for 20 cycles with all strobes 0. RESET=1 for one edge -> START, Halt=0.
- MEM_WAIT=2: DECODE -> WAIT for exactly 2 cycles with Meminst=1 -> EXECUTE. Instruction spans 5 cycles.
- With UP_CU_INPUT_HANDSHAKE_EN: IN with Enter low 4 cycles -> INWAIT for 4 cycles, Aload=0. Enter=1 -> Aload=1, Asel=01 that cycle, then FETCH. RESET asserted in INWAIT -> START.

Source files
------------

// File: rtl/up_cu_pkg.sv
// up_cu_pkg: shared definitions for the accumulator-machine control unit.
//   - opcode values carried in IR[7:5]
//   - FSM state encodings (also exported on the State debug port)
//   - Asel codes selecting the A-register input source
package up_cu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    ST_START   = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_WAIT    = 3'b011,
    ST_EXECUTE = 3'b100,
    ST_INWAIT  = 3'b101,
    ST_HALT    = 3'b111
  } state_t;

  localparam logic [1:0] ASEL_RESULT = 2'b00;
  localparam logic [1:0] ASEL_INPUT  = 2'b01;
  localparam logic [1:0] ASEL_RAM    = 2'b10;

endpackage

// File: rtl/up_cu_outdec.sv
// up_cu_outdec: combinational Moore decoder from FSM state + opcode + datapath
// flags to the datapath control strobes. All strobes default to 0.
// Ports:
//   state              current FSM state
//   ir [2:0]           opcode IR[7:5]
//   aeq0, apos         A == 0, A >= 0 (signed)
//   enter              input-valid strobe (only meaningful with
//                      UP_CU_INPUT_HANDSHAKE_EN defined)
//   irload..halt       control strobes to the datapath
// Optional feature macro: UP_CU_INPUT_HANDSHAKE_EN
module up_cu_outdec
  import up_cu_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] ir,
  input  logic       aeq0,
  input  logic       apos,
  input  logic       enter,
  output logic       irload,
  output logic       jmpmux,
  output logic       pcload,
  output logic       meminst,
  output logic       memwr,
  output logic       aload,
  output logic       sub,
  output logic [1:0] asel,
  output logic       halt
);

`ifndef UP_CU_INPUT_HANDSHAKE_EN
  // Without the handshake the input strobe has no effect on any output.
  logic unused_enter;
  assign unused_enter = enter;
`endif

  always_comb begin
    irload  = 1'b0;
    jmpmux  = 1'b0;
    pcload  = 1'b0;
    meminst = 1'b0;
    memwr   = 1'b0;
    aload   = 1'b0;
    sub     = 1'b0;
    asel    = ASEL_RESULT;
    halt    = 1'b0;
    case (state)
      ST_FETCH: begin
        // IR <- RAM[PC], PC <- PC+1 in the same edge
        irload = 1'b1;
        pcload = 1'b1;
      end
      ST_DECODE, ST_WAIT: begin
        // Hold the operand address on the RAM while it settles
        meminst = 1'b1;
      end
      ST_EXECUTE: begin
        case (ir)
          OP_LOAD: begin
            meminst = 1'b1;
            asel    = ASEL_RAM;
            aload   = 1'b1;
          end
          OP_STORE: begin
            meminst = 1'b1;
            memwr   = 1'b1;
          end
          OP_ADD: begin
            meminst = 1'b1;
            aload   = 1'b1;
          end
          OP_SUB: begin
            meminst = 1'b1;
            sub     = 1'b1;
            aload   = 1'b1;
          end
          OP_IN: begin
`ifdef UP_CU_INPUT_HANDSHAKE_EN
            // Load only when the input is already valid; otherwise the
            // FSM parks in INWAIT with all strobes low.
            if (enter) begin
              asel  = ASEL_INPUT;
              aload = 1'b1;
            end
`else
            asel  = ASEL_INPUT;
            aload = 1'b1;
`endif
          end
          OP_JZ: begin
            if (aeq0) begin
              jmpmux = 1'b1;
              pcload = 1'b1;
            end
          end
          OP_JPOS: begin
            if (apos) begin
              jmpmux = 1'b1;
              pcload = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_INWAIT: begin
`ifdef UP_CU_INPUT_HANDSHAKE_EN
        if (enter) begin
          asel  = ASEL_INPUT;
          aload = 1'b1;
        end
`endif
      end
      ST_HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/up_control_unit.sv
// up_control_unit: fetch/decode/execute FSM for the 8-bit accumulator machine.
// Holds the state register, next-state logic and the RAM wait counter; the
// strobe decode lives in up_cu_outdec.
// Parameters:
//   MEM_WAIT  extra DECODE->EXECUTE wait cycles (0..7)
//   WAITW     wait counter width
// Ports:
//   CLOCK, RESET          clock, synchronous active-high reset
//   IR [2:0], Aeq0, Apos  datapath status
//   Enter                 input-valid strobe
//   IRload..Halt          datapath control strobes
//   State [2:0]           current state (debug)
// Optional feature macro: UP_CU_INPUT_HANDSHAKE_EN (IN waits for Enter)
module up_control_unit
  import up_cu_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int WAITW    = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       Halt,
  output logic [2:0] State
);

  // Counter preload so that WAIT lasts exactly MEM_WAIT cycles (exits on 0).
  localparam logic [WAITW-1:0] WAIT_INIT =
    (MEM_WAIT > 0) ? WAITW'(MEM_WAIT - 1) : '0;

  state_t           state_reg, state_next;
  logic [WAITW-1:0] wait_cnt_reg, wait_cnt_next;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg    <= ST_START;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_START:  state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        if (IR == OP_HALT) begin
          state_next = ST_HALT;
        end else if (MEM_WAIT > 0) begin
          state_next    = ST_WAIT;
          wait_cnt_next = WAIT_INIT;
        end else begin
          state_next = ST_EXECUTE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == '0) state_next = ST_EXECUTE;
        else                    wait_cnt_next = wait_cnt_reg - 1'b1;
      end
      ST_EXECUTE: begin
`ifdef UP_CU_INPUT_HANDSHAKE_EN
        if (IR == OP_IN && !Enter) state_next = ST_INWAIT;
        else                       state_next = ST_FETCH;
`else
        state_next = ST_FETCH;
`endif
      end
      ST_INWAIT: begin
`ifdef UP_CU_INPUT_HANDSHAKE_EN
        if (Enter) state_next = ST_FETCH;
`else
        // Unreachable without the handshake; recover to the fetch loop.
        state_next = ST_FETCH;
`endif
      end
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_START;
    endcase
  end

  assign State = state_reg;

  up_cu_outdec u_outdec (
    .state   (state_reg),
    .ir      (IR),
    .aeq0    (Aeq0),
    .apos    (Apos),
    .enter   (Enter),
    .irload  (IRload),
    .jmpmux  (JMPmux),
    .pcload  (PCload),
    .meminst (Meminst),
    .memwr   (MemWr),
    .aload   (Aload),
    .sub     (Sub),
    .asel    (Asel),
    .halt    (Halt)
  );

endmodule
